// File: rtl/des_pkg.sv
// Shared DES definitions: S-box tables, round-stage FSM states and datapath widths.
// Used by the expansion, key schedule, S-box substitution and P-box stages.
package des_pkg;

    localparam int DES_HALF_W = 32;
    localparam int DES_EXP_W  = 48;

    typedef logic [3:0] sbox_t [0:3][0:15];

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // FIPS 46-3 tables, S1..S8, each row indexed by the 4-bit column.
    localparam sbox_t SBOX [0:7] = '{
        '{ '{4'hE,4'h4,4'hD,4'h1,4'h2,4'hF,4'hB,4'h8,4'h3,4'hA,4'h6,4'hC,4'h5,4'h9,4'h0,4'h7},
           '{4'h0,4'hF,4'h7,4'h4,4'hE,4'h2,4'hD,4'h1,4'hA,4'h6,4'hC,4'hB,4'h9,4'h5,4'h3,4'h8},
           '{4'h4,4'h1,4'hE,4'h8,4'hD,4'h6,4'h2,4'hB,4'hF,4'hC,4'h9,4'h7,4'h3,4'hA,4'h5,4'h0},
           '{4'hF,4'hC,4'h8,4'h2,4'h4,4'h9,4'h1,4'h7,4'h5,4'hB,4'h3,4'hE,4'hA,4'h0,4'h6,4'hD} },
        '{ '{4'hF,4'h1,4'h8,4'hE,4'h6,4'hB,4'h3,4'h4,4'h9,4'h7,4'h2,4'hD,4'hC,4'h0,4'h5,4'hA},
           '{4'h3,4'hD,4'h4,4'h7,4'hF,4'h2,4'h8,4'hE,4'hC,4'h0,4'h1,4'hA,4'h6,4'h9,4'hB,4'h5},
           '{4'h0,4'hE,4'h7,4'hB,4'hA,4'h4,4'hD,4'h1,4'h5,4'h8,4'hC,4'h6,4'h9,4'h3,4'h2,4'hF},
           '{4'hD,4'h8,4'hA,4'h1,4'h3,4'hF,4'h4,4'h2,4'hB,4'h6,4'h7,4'hC,4'h0,4'h5,4'hE,4'h9} },
        '{ '{4'hA,4'h0,4'h9,4'hE,4'h6,4'h3,4'hF,4'h5,4'h1,4'hD,4'hC,4'h7,4'hB,4'h4,4'h2,4'h8},
           '{4'hD,4'h7,4'h0,4'h9,4'h3,4'h4,4'h6,4'hA,4'h2,4'h8,4'h5,4'hE,4'hC,4'hB,4'hF,4'h1},
           '{4'hD,4'h6,4'h4,4'h9,4'h8,4'hF,4'h3,4'h0,4'hB,4'h1,4'h2,4'hC,4'h5,4'hA,4'hE,4'h7},
           '{4'h1,4'hA,4'hD,4'h0,4'h6,4'h9,4'h8,4'h7,4'h4,4'hF,4'hE,4'h3,4'hB,4'h5,4'h2,4'hC} },
        '{ '{4'h7,4'hD,4'hE,4'h3,4'h0,4'h6,4'h9,4'hA,4'h1,4'h2,4'h8,4'h5,4'hB,4'hC,4'h4,4'hF},
           '{4'hD,4'h8,4'hB,4'h5,4'h6,4'hF,4'h0,4'h3,4'h4,4'h7,4'h2,4'hC,4'h1,4'hA,4'hE,4'h9},
           '{4'hA,4'h6,4'h9,4'h0,4'hC,4'hB,4'h7,4'hD,4'hF,4'h1,4'h3,4'hE,4'h5,4'h2,4'h8,4'h4},
           '{4'h3,4'hF,4'h0,4'h6,4'hA,4'h1,4'hD,4'h8,4'h9,4'h4,4'h5,4'hB,4'hC,4'h7,4'h2,4'hE} },
        '{ '{4'h2,4'hC,4'h4,4'h1,4'h7,4'hA,4'hB,4'h6,4'h8,4'h5,4'h3,4'hF,4'hD,4'h0,4'hE,4'h9},
           '{4'hE,4'hB,4'h2,4'hC,4'h4,4'h7,4'hD,4'h1,4'h5,4'h0,4'hF,4'hA,4'h3,4'h9,4'h8,4'h6},
           '{4'h4,4'h2,4'h1,4'hB,4'hA,4'hD,4'h7,4'h8,4'hF,4'h9,4'hC,4'h5,4'h6,4'h3,4'h0,4'hE},
           '{4'hB,4'h8,4'hC,4'h7,4'h1,4'hE,4'h2,4'hD,4'h6,4'hF,4'h0,4'h9,4'hA,4'h4,4'h5,4'h3} },
        '{ '{4'hC,4'h1,4'hA,4'hF,4'h9,4'h2,4'h6,4'h8,4'h0,4'hD,4'h3,4'h4,4'hE,4'h7,4'h5,4'hB},
           '{4'hA,4'hF,4'h4,4'h2,4'h7,4'hC,4'h9,4'h5,4'h6,4'h1,4'hD,4'hE,4'h0,4'hB,4'h3,4'h8},
           '{4'h9,4'hE,4'hF,4'h5,4'h2,4'h8,4'hC,4'h3,4'h7,4'h0,4'h4,4'hA,4'h1,4'hD,4'hB,4'h6},
           '{4'h4,4'h3,4'h2,4'hC,4'h9,4'h5,4'hF,4'hA,4'hB,4'hE,4'h1,4'h7,4'h6,4'h0,4'h8,4'hD} },
        '{ '{4'h4,4'hB,4'h2,4'hE,4'hF,4'h0,4'h8,4'hD,4'h3,4'hC,4'h9,4'h7,4'h5,4'hA,4'h6,4'h1},
           '{4'hD,4'h0,4'hB,4'h7,4'h4,4'h9,4'h1,4'hA,4'hE,4'h3,4'h5,4'hC,4'h2,4'hF,4'h8,4'h6},
           '{4'h1,4'h4,4'hB,4'hD,4'hC,4'h3,4'h7,4'hE,4'hA,4'hF,4'h6,4'h8,4'h0,4'h5,4'h9,4'h2},
           '{4'h6,4'hB,4'hD,4'h8,4'h1,4'h4,4'hA,4'h7,4'h9,4'h5,4'h0,4'hF,4'hE,4'h2,4'h3,4'hC} },
        '{ '{4'hD,4'h2,4'h8,4'h4,4'h6,4'hF,4'hB,4'h1,4'hA,4'h9,4'h3,4'hE,4'h5,4'h0,4'hC,4'h7},
           '{4'h1,4'hF,4'hD,4'h8,4'hA,4'h3,4'h7,4'h4,4'hC,4'h5,4'h6,4'hB,4'h0,4'hE,4'h9,4'h2},
           '{4'h7,4'hB,4'h4,4'h1,4'h9,4'hC,4'hE,4'h2,4'h0,4'h6,4'hA,4'hD,4'hF,4'h3,4'h5,4'h8},
           '{4'h2,4'h1,4'hE,4'h7,4'h4,4'hA,4'h8,4'hD,4'hF,4'hC,4'h9,4'h0,4'h3,4'h5,4'h6,4'hB} }
    };

endpackage

// File: rtl/sbox_substitution_if.sv
// Start/busy/done request bundle between the key-mix stage and the S-box substitution stage.
interface sbox_substitution_if #(
    parameter int IN_W  = des_pkg::DES_EXP_W,
    parameter int OUT_W = des_pkg::DES_HALF_W
);
    logic             start;
    logic [IN_W-1:0]  data_in;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] data_out;

    modport master (
        output start,
        output data_in,
        input  busy,
        input  done,
        input  data_out
    );

    modport slave (
        input  start,
        input  data_in,
        output busy,
        output done,
        output data_out
    );
endinterface

// File: rtl/sbox_lookup.sv
// Single combinational S-box lookup: selects table `box` and maps a 6-bit group to a nibble.
// Kept standalone so a fully parallel round can instantiate eight of them.
module sbox_lookup
    import des_pkg::*;
(
    input  logic [2:0] box,
    input  logic [5:0] six,
    output logic [3:0] nib
);

    logic [1:0] row;
    logic [3:0] col;

    // Outer bits pick the row, the inner four bits pick the column.
    always_comb begin
        row = {six[5], six[0]};
        col = six[4:1];
        nib = SBOX[box][row][col];
    end

endmodule

// File: rtl/sbox_substitution.sv
// Iterative DES 48->32 S-box stage: one lookup per clock through a shared sbox_lookup,
// MSB-first group order, with a start/busy/done handshake.
module sbox_substitution
    import des_pkg::*;
#(
    parameter int NUM_BOXES = 8,
    parameter int IN_W      = NUM_BOXES * 6,
    parameter int OUT_W     = NUM_BOXES * 4
) (
    input  logic               clk,
    input  logic               n_rst,
    sbox_substitution_if.slave bus
);

    localparam int                CNT_W    = $clog2(NUM_BOXES);
    localparam logic [CNT_W-1:0]  LAST_BOX = CNT_W'(NUM_BOXES - 1);

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic [IN_W-1:0]    in_sr_q,    in_sr_d;
    logic [OUT_W-1:0]   out_sr_q,   out_sr_d;
    logic [OUT_W-1:0]   data_out_q, data_out_d;
    logic [3:0]         nib;
    logic [OUT_W-1:0]   out_sr_shifted;

    sbox_lookup u_lookup (
        .box (count_q),
        .six (in_sr_q[IN_W-1 -: 6]),
        .nib (nib)
    );

    assign out_sr_shifted = {out_sr_q[OUT_W-5:0], nib};

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        in_sr_d    = in_sr_q;
        out_sr_d   = out_sr_q;
        data_out_d = data_out_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    in_sr_d  = bus.data_in;
                    out_sr_d = '0;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                out_sr_d = out_sr_shifted;
                in_sr_d  = in_sr_q << 6;
                count_d  = count_q + 1'b1;
                // The last group's nibble is folded in directly so data_out is complete on entry to DONE.
                if (count_q == LAST_BOX) begin
                    data_out_d = out_sr_shifted;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            in_sr_q    <= '0;
            out_sr_q   <= '0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            in_sr_q    <= in_sr_d;
            out_sr_q   <= out_sr_d;
            data_out_q <= data_out_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_sbox_substitution.sv
// Directed bench for sbox_substitution: expected words go into a queue at launch and are
// popped when done is seen; latency, busy width, hold behaviour and reset abort are checked.
module tb_sbox_substitution;

    logic clk = 1'b0;
    logic n_rst;

    always #5 clk = ~clk;

    sbox_substitution_if bus ();

    sbox_substitution dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q [$];

    // Independent reference table: one 64-bit word per (box,row), column 0 in the top nibble.
    localparam logic [63:0] TB_ROWS [0:31] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    function automatic logic [31:0] ref_model(input logic [47:0] w);
        logic [31:0] r;
        logic [5:0]  g;
        logic [63:0] row_bits;
        int          rr;
        int          cc;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            g        = w[47 - 6*b -: 6];
            rr       = int'({g[5], g[0]});
            cc       = int'(g[4:1]);
            row_bits = TB_ROWS[b*4 + rr];
            r[31 - 4*b -: 4] = row_bits[63 - 4*cc -: 4];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive a one-cycle start from IDLE and record the expected result.
    task automatic launch(input logic [47:0] din, input logic [31:0] expv);
        bus.data_in = din;
        bus.start   = 1'b1;
        exp_q.push_back(expv);
        tick();
        bus.start   = 1'b0;
    endtask

    // Wait (bounded) for done, then check timing, busy width, output hold and the result.
    task automatic collect(input string tag, input int exp_lat);
        int          lat;
        int          busy_cycles;
        bit          moved;
        logic [31:0] hold;
        logic [31:0] expv;
        lat         = 0;
        busy_cycles = 0;
        moved       = 1'b0;
        hold        = bus.data_out;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.data_out !== hold) moved = 1'b1;
            tick();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy_cycles"}, 64'(busy_cycles), 64'(exp_lat));
        check({tag, " busy_in_done"}, 64'(bus.busy), 64'd0);
        check({tag, " out_held_while_busy"}, 64'(moved), 64'd0);
        if (exp_q.size() == 0) expv = 'x;
        else                   expv = exp_q.pop_front();
        check({tag, " data_out"}, 64'(bus.data_out), 64'(expv));
        $display("[TB] %s: data_out=%08h expected=%08h latency=%0d", tag, bus.data_out, expv, lat);
    endtask

    initial begin
        logic [47:0] din;
        logic [31:0] prev;
        int          n_done;

        n_rst       = 1'b0;
        bus.start   = 1'b0;
        bus.data_in = '0;
        tick();
        tick();
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset data_out", 64'(bus.data_out), 64'd0);
        n_rst = 1'b1;
        tick();

        // All-zero word.
        launch(48'h000000000000, 32'hEFA72C4D);
        collect("zero", 8);
        tick();

        // Reset in the 4th RUN cycle aborts the op and clears outputs at once.
        bus.data_in = 48'h6117BA866527;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        tick();
        tick();
        tick();
        n_rst = 1'b0;
        #1;
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort done", 64'(bus.done), 64'd0);
        check("abort data_out", 64'(bus.data_out), 64'd0);
        tick();
        n_rst  = 1'b1;
        n_done = 0;
        repeat (15) begin
            tick();
            if (bus.done === 1'b1) n_done++;
        end
        check("abort no done", 64'(n_done), 64'd0);

        // All-ones word.
        launch(48'hFFFFFFFFFFFF, 32'hD9CE3DCB);
        collect("ones", 8);
        tick();

        // FIPS round-1 vector.
        launch(48'h6117BA866527, 32'h5C82B597);
        collect("fips", 8);
        tick();

        // A start pulse during RUN is ignored and not queued.
        din = {16'($urandom), $urandom};
        launch(din, ref_model(din));
        bus.data_in = 48'h0;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        tick();
        collect("start_in_run", 6);
        n_done = 0;
        repeat (12) begin
            tick();
            if (bus.done === 1'b1) n_done++;
        end
        check("start_in_run no extra done", 64'(n_done), 64'd0);

        // Start held high: a new op on each IDLE re-entry, done every 10 cycles.
        bus.start = 1'b1;
        prev      = bus.data_out;
        for (int k = 0; k < 3; k++) begin
            din         = {16'($urandom), $urandom};
            bus.data_in = din;
            exp_q.push_back(ref_model(din));
            if (k != 0) begin
                tick();
                check("held gap done", 64'(bus.done), 64'd0);
                check("held gap data_out", 64'(bus.data_out), 64'(prev));
            end
            tick();
            if (k == 2) bus.start = 1'b0;
            collect("held", 8);
            prev = ref_model(din);
        end
        tick();

        // data_in changes while busy have no effect; data_out holds after done.
        din = {16'($urandom), $urandom};
        launch(din, ref_model(din));
        bus.data_in = ~din;
        tick();
        bus.data_in = {16'($urandom), $urandom};
        collect("din_change", 7);
        repeat (5) begin
            bus.data_in = {16'($urandom), $urandom};
            tick();
        end
        check("hold after done", 64'(bus.data_out), 64'(ref_model(din)));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
